// File: rtl/psk_tx_pkg.sv
// Shared types, symbol-offset constants and the output saturation helper for the PSK transmitter.
// Pure declarations: no latency, no flow control.
package psk_tx_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, MOD, DRAIN} state_t;

    typedef enum logic {MODE_BPSK = 1'b0, MODE_QPSK = 1'b1} mode_t;

    // Symbol offsets are counted in quarter turns of the carrier phase.
    localparam logic [1:0] BPSK_QTR = 2'd2;
    localparam logic [1:0] QPSK_QTR = 2'd1;

    function automatic logic [1:0] sym_quarters(input mode_t m, input logic msb, input logic lsb);
        logic [1:0] s;
        s = (m == MODE_QPSK) ? {msb, lsb} : {1'b0, lsb};
        return (m == MODE_QPSK) ? s * QPSK_QTR : s * BPSK_QTR;
    endfunction

    function automatic int sat(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/psk_sine_lut.sv
// Quarter-wave sine ROM addressed by quadrant + index; 1-cycle registered output.
// No backpressure of its own: the output register only updates when load is high.
module psk_sine_lut #(
    parameter int DATA_W = 16,
    parameter int LUT_AW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [LUT_AW+1:0]        addr,
    output logic signed [DATA_W-1:0] sine
);

    localparam int N = 2 ** LUT_AW;

    // N+1 entries so the mirrored quadrants reach the exact peak at index N.
    typedef logic [DATA_W-2:0] tab_t [N+1];

    function automatic tab_t build_tab();
        tab_t t;
        real  amp;
        amp = real'(2 ** (DATA_W - 1) - 1);
        for (int i = 0; i <= N; i++) begin
            t[i] = (DATA_W-1)'($rtoi(amp * $sin(3.14159265358979 / 2.0 * real'(i) / real'(N)) + 0.5));
        end
        return t;
    endfunction

    localparam tab_t TAB = build_tab();

    logic [1:0]               quad;
    logic [LUT_AW-1:0]        idx;
    logic [LUT_AW:0]          tidx;
    logic signed [DATA_W-1:0] mag;
    logic signed [DATA_W-1:0] val;

    assign quad = addr[LUT_AW+1:LUT_AW];
    assign idx  = addr[LUT_AW-1:0];
    assign tidx = quad[0] ? ((LUT_AW+1)'(N) - {1'b0, idx}) : {1'b0, idx};
    assign mag  = {1'b0, TAB[tidx]};
    assign val  = quad[1] ? -mag : mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sine <= '0;
        end else if (load) begin
            sine <= val;
        end
    end

endmodule

// File: rtl/psk_tx_core.sv
// BPSK/QPSK modulator: serial bits in, SPS sine samples per symbol out; first sample 2 cycles after the completing bit.
// Sample stalls hold the output register; bit_ready drops when the one-symbol look-ahead is full. Noise: PSK_TX_NOISE_EN.
module psk_tx_core
    import psk_tx_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8,
    parameter int SPS     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [PHASE_W-1:0]        fcw,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    input  logic signed [DATA_W-1:0]  noise_in,
    output logic signed [DATA_W-1:0]  sample_out,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      busy,
    output logic                      underrun
);

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int SMAX  = 2 ** (DATA_W - 1) - 1;
    localparam int SMIN  = -(2 ** (DATA_W - 1));

    state_t                   state, state_nxt;
    logic [PHASE_W-1:0]       phase_acc, lut_phase;
    logic [LUT_AW+1:0]        lut_addr;
    logic [CNT_W-1:0]         cnt;
    logic [1:0]               cur_q, buf_q, new_q;
    logic                     cur_vld, buf_full, asm_have, asm_msb;
    mode_t                    asm_mode, mode_eff;
    logic                     bit_fire, sym_done, issue, last, accept, underrun_nxt;
    logic signed [DATA_W-1:0] sine;

    assign mode_eff  = asm_have ? asm_mode : mode_t'(mode);
    assign bit_ready = en && ((state == COLLECT) || ((state == MOD) && !buf_full));
    assign bit_fire  = bit_valid && bit_ready;
    assign sym_done  = bit_fire && ((mode_eff == MODE_BPSK) || asm_have);
    assign new_q     = sym_quarters(mode_eff, asm_msb, bit_in);
    assign accept    = sample_valid && sample_ready;
    assign issue     = cur_vld && (!sample_valid || sample_ready);
    assign last      = issue && (cnt == CNT_W'(SPS - 1));
    assign busy      = (state == MOD) || (state == DRAIN);

    // A sample issued while the previous one is being accepted must see the advanced phase.
    assign lut_phase = phase_acc + (sample_valid ? fcw : '0) + {cur_q, {(PHASE_W-2){1'b0}}};
    assign lut_addr  = (LUT_AW+2)'(lut_phase >> (PHASE_W - LUT_AW - 2));

    always_comb begin
        state_nxt    = state;
        underrun_nxt = 1'b0;
        case (state)
            IDLE:    if (en) state_nxt = COLLECT;
            COLLECT: begin
                if (sym_done) state_nxt = MOD;
                else if (!en && (!sample_valid || sample_ready)) state_nxt = IDLE;
            end
            MOD: begin
                if (!en) begin
                    state_nxt = DRAIN;
                end else if (last && !buf_full && !sym_done) begin
                    state_nxt    = COLLECT;
                    underrun_nxt = 1'b1;
                end
            end
            DRAIN:   if (!cur_vld && (!sample_valid || sample_ready)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            underrun     <= 1'b0;
            phase_acc    <= '0;
            cnt          <= '0;
            sample_valid <= 1'b0;
            cur_q        <= '0;
            cur_vld      <= 1'b0;
            buf_q        <= '0;
            buf_full     <= 1'b0;
            asm_have     <= 1'b0;
            asm_msb      <= 1'b0;
            asm_mode     <= MODE_BPSK;
        end else begin
            state    <= state_nxt;
            underrun <= underrun_nxt;

            if (state_nxt == IDLE) phase_acc <= '0;
            else if (accept)       phase_acc <= phase_acc + fcw;

            if (issue) begin
                sample_valid <= 1'b1;
                cnt          <= last ? '0 : cnt + CNT_W'(1);
            end else if (accept) begin
                sample_valid <= 1'b0;
            end

            if ((state == COLLECT) && sym_done) begin
                cur_q   <= new_q;
                cur_vld <= 1'b1;
            end else if (last) begin
                if ((state == MOD) && en && buf_full)      cur_q   <= buf_q;
                else if ((state == MOD) && en && sym_done) cur_q   <= new_q;
                else                                       cur_vld <= 1'b0;
            end

            // A symbol completing on the last sample bypasses the buffer straight into cur.
            if ((state != MOD) || !en) begin
                buf_full <= 1'b0;
            end else if (last) begin
                buf_full <= 1'b0;
            end else if (sym_done) begin
                buf_q    <= new_q;
                buf_full <= 1'b1;
            end

            if (!en || (state == IDLE) || (state == DRAIN)) begin
                asm_have <= 1'b0;
            end else if (bit_fire) begin
                asm_have <= !sym_done;
                asm_msb  <= bit_in;
                if (!asm_have) asm_mode <= mode_t'(mode);
            end
        end
    end

    psk_sine_lut #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk  (clk),
        .rst  (rst),
        .load (issue),
        .addr (lut_addr),
        .sine (sine)
    );

`ifdef PSK_TX_NOISE_EN
    logic signed [DATA_W-1:0] noise_q;
    logic signed [DATA_W:0]   noisy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        noise_q <= '0;
        else if (issue) noise_q <= noise_in;
    end

    assign noisy      = {sine[DATA_W-1], sine} + {noise_q[DATA_W-1], noise_q};
    assign sample_out = DATA_W'(sat(int'(noisy), SMIN, SMAX));
`else
    logic unused_noise;
    assign unused_noise = ^noise_in;
    assign sample_out   = sine;
`endif

endmodule

// File: tb/tb_psk_tx_core.sv
// Directed bench for psk_tx_core with SPS=4 and fcw a quarter turn; expected samples are hand-computed sine points.
module tb_psk_tx_core;

    logic               clk, rst, en, mode, bit_in, bit_valid, bit_ready;
    logic [15:0]        fcw;
    logic signed [15:0] noise_in, sample_out;
    logic               sample_valid, sample_ready, busy, underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int got[$];
    int gcyc[$];
    int ur_cnt = 0;
    int ur_idx = 0;

    psk_tx_core #(.DATA_W(16), .PHASE_W(16), .LUT_AW(8), .SPS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .fcw          (fcw),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .noise_in     (noise_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            got.push_back(int'(sample_out));
            gcyc.push_back(cyc);
        end
        if (!rst && underrun) begin
            ur_cnt++;
            ur_idx = got.size();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic keep);
        logic done;
        int   k;
        bit_in    = b;
        bit_valid = 1'b1;
        done      = 1'b0;
        k         = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            done = bit_ready;
            tick();
            k++;
        end
        if (!done) check("bit_ready_timeout", 0, 1);
        if (!keep) bit_valid = 1'b0;
    endtask

    task automatic wait_samples(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 300) begin
            tick();
            k++;
        end
        if (got.size() < n) check("sample_timeout", got.size(), n);
    endtask

    task automatic check_sym(input string tag, input int base, input int e0, input int e1,
                             input int e2, input int e3);
        int e[4];
        int obs;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            obs = (base + i < got.size()) ? got[base + i] : 32'h7fff_ffff;
            check($sformatf("%s[%0d]", tag, i), obs, e[i]);
        end
    endtask

    initial begin
        int base, ur0, held, nvld;

        rst = 1'b1; en = 1'b1; mode = 1'b0; fcw = 16'd16384;
        bit_in = 1'b0; bit_valid = 1'b0; noise_in = '0; sample_ready = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_bit_ready", int'(bit_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_underrun", int'(underrun), 0);
        tick();
        rst = 1'b0;

        // BPSK bit 0 with first-sample latency and the underrun that follows a lone symbol
        base = got.size(); ur0 = ur_cnt;
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", int'(sample_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", int'(sample_valid), 1);
        check("busy_in_mod", int'(busy), 1);
        tick();
        wait_samples(base + 4);
        tick();
        check_sym("bpsk_b0", base, 0, 32767, 0, -32767);
        check("single_underrun_cnt", ur_cnt - ur0, 1);
        check("single_underrun_at", ur_idx - base, 4);

        base = got.size();
        send_bit(1'b1, 1'b0);
        wait_samples(base + 4);
        check_sym("bpsk_b1", base, 0, -32767, 0, 32767);

`ifdef PSK_TX_NOISE_EN
        noise_in = 16'sd100;
        base = got.size();
        send_bit(1'b0, 1'b0);
        wait_samples(base + 4);
        check_sym("noise_p100", base, 100, 32767, 100, -32667);
        noise_in = -16'sd200;
        base = got.size();
        send_bit(1'b0, 1'b0);
        wait_samples(base + 4);
        check_sym("noise_m200", base, -200, 32567, -200, -32768);
        noise_in = '0;
`endif

        // QPSK: bits 0,1 then 1,1 streamed, first bit is the MSB
        mode = 1'b1;
        base = got.size();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        wait_samples(base + 8);
        check_sym("qpsk_s1", base, 32767, 0, -32767, 0);
        check_sym("qpsk_s3", base + 4, -32767, 0, 32767, 0);
        mode = 1'b0;
        repeat (3) tick();

        // Sink stall of 5 cycles on the second sample
        base = got.size();
        send_bit(1'b0, 1'b0);
        wait_samples(base + 1);
        sample_ready = 1'b0;
        held = int'(sample_out);
        check("bp_held_value", held, 32767);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(sample_valid), 1);
            check("bp_hold_data", int'(sample_out), held);
            tick();
        end
        sample_ready = 1'b1;
        wait_samples(base + 4);
        repeat (6) tick();
        check("bp_sample_count", got.size() - base, 4);
        check_sym("bp_seq", base, 0, 32767, 0, -32767);

        // Three back-to-back BPSK symbols, then starve the core
        base = got.size(); ur0 = ur_cnt;
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        wait_samples(base + 12);
        repeat (2) tick();
        check_sym("stream_s0", base, 0, 32767, 0, -32767);
        check_sym("stream_s1", base + 4, 0, -32767, 0, 32767);
        check_sym("stream_s2", base + 8, 0, 32767, 0, -32767);
        check("stream_contiguous", (got.size() >= base + 12) ? gcyc[base + 11] - gcyc[base] : -1, 11);
        check("stream_underrun_cnt", ur_cnt - ur0, 1);
        check("stream_underrun_at", ur_idx - base, 12);

        // en falls mid-symbol with a buffered symbol: finish current, drop buffer
        base = got.size(); ur0 = ur_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        wait_samples(base + 1);
        en = 1'b0;
        @(negedge clk);
        check("drain_bit_ready", int'(bit_ready), 0);
        tick();
        @(negedge clk);
        check("drain_busy", int'(busy), 1);
        tick();
        wait_samples(base + 4);
        repeat (8) tick();
        check("drain_sample_count", got.size() - base, 4);
        check_sym("drain_seq", base, 0, -32767, 0, 32767);
        check("drain_idle_busy", int'(busy), 0);
        check("drain_no_underrun", ur_cnt - ur0, 0);

        // Reset at the second sample, then restart from phase 0
        en = 1'b1;
        base = got.size();
        send_bit(1'b1, 1'b0);
        wait_samples(base + 1);
        #2;
        check("rst_mid_pre_data", int'(sample_out), -32767);
        rst = 1'b1;
        #1;
        check("rst_mid_sample_out", int'(sample_out), 0);
        check("rst_mid_sample_valid", int'(sample_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_bit_ready", int'(bit_ready), 0);
        check("rst_mid_underrun", int'(underrun), 0);
        tick();
        tick();
        rst = 1'b0;
        nvld = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sample_valid) nvld++;
            tick();
        end
        check("rst_no_partial", nvld, 0);
        base = got.size();
        send_bit(1'b0, 1'b0);
        wait_samples(base + 4);
        check_sym("rst_restart", base, 0, 32767, 0, -32767);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
